// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array edge feeder.
package sa_pkg;

  localparam int unsigned MUL_BW_DEF = 16;
  localparam int unsigned ADD_BW_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SHIFT,
    COMPUTE,
    DRAIN
  } feeder_state_t;

  // Cycles needed for the last injected element to cross the whole array.
  function automatic int unsigned drain_len(input int unsigned rows,
                                            input int unsigned cols,
                                            input int unsigned pipe_lat);
    return rows + cols - 1 + pipe_lat;
  endfunction

endpackage

// File: rtl/sa_edge_feeder_if.sv
// Weight-row and activation-vector streams between tile buffer and feeder.
interface sa_edge_feeder_if
  import sa_pkg::*;
#(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned MUL_BW = MUL_BW_DEF
) ();

  logic                     w_valid;
  logic                     w_ready;
  logic [COLS*MUL_BW-1:0]   w_data;

  logic                     a_valid;
  logic                     a_ready;
  logic                     a_last;
  logic [ROWS*MUL_BW-1:0]   a_data;

  modport master (
    output w_valid, w_data, a_valid, a_last, a_data,
    input  w_ready, a_ready
  );

  modport slave (
    input  w_valid, w_data, a_valid, a_last, a_data,
    output w_ready, a_ready
  );

endinterface

// File: rtl/sa_skew_line.sv
// Data+valid delay line: DEPTH extra stages behind one output register.
module sa_skew_line #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  input  logic         v_i,
  output logic [W-1:0] d_o,
  output logic         v_o
);

  logic [W-1:0] d_q [DEPTH+1];
  logic [DEPTH:0] v_q;

  // Shift data and valid together; stage 0 is the input capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '{default: '0};
      v_q <= '0;
    end else begin
      d_q[0] <= d_i;
      v_q[0] <= v_i;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        d_q[k] <= d_q[k-1];
        v_q[k] <= v_q[k-1];
      end
    end
  end

  assign d_o = d_q[DEPTH];
  assign v_o = v_q[DEPTH];

endmodule

// File: rtl/sa_edge_feeder.sv
// Edge driver for the weight-stationary systolic array: collects a weight
// tile, shifts it down the columns, then injects skewed activation vectors
// and drains the pipeline.
// Optional: define SA_EDGE_FEEDER_PERF_CNT_EN for bubble/stall counters.
module sa_edge_feeder
  import sa_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned MUL_BW   = MUL_BW_DEF,
  parameter int unsigned ADD_BW   = ADD_BW_DEF,
  parameter int unsigned PIPE_LAT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  sa_edge_feeder_if.slave        s_if,
  output logic                   o_mode,
  output logic [COLS*ADD_BW-1:0] o_top,
  output logic [ROWS*MUL_BW-1:0] o_left,
  output logic [ROWS-1:0]        o_row_valid,
  output logic                   o_busy,
  output logic                   o_done
`ifdef SA_EDGE_FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]            o_bubble_cnt,
  output logic [31:0]            o_wstall_cnt
`endif
);

  localparam int unsigned DRAIN_LEN = drain_len(ROWS, COLS, PIPE_LAT);
  localparam int unsigned CNT_W     = $clog2(DRAIN_LEN + 1);
  localparam int unsigned IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] ROWS_C  = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0] DRAIN_C = CNT_W'(DRAIN_LEN);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  feeder_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic w_ready_q, w_ready_d;
  logic a_ready_q, a_ready_d;
  logic mode_q, mode_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [COLS*ADD_BW-1:0] top_q, top_d;
  logic [COLS*MUL_BW-1:0] wbuf_q [ROWS];

  logic w_fire, a_fire;
  logic [IDX_W-1:0] widx, ridx;

  assign w_fire = (state_q == COLLECT) && s_if.w_valid && w_ready_q;
  assign a_fire = (state_q == COMPUTE) && s_if.a_valid && a_ready_q;
  assign widx   = cnt_q[IDX_W-1:0];
  assign ridx   = IDX_W'(ROWS_C - ONE_C - cnt_q);

  function automatic logic [COLS*ADD_BW-1:0] zext_row(input logic [COLS*MUL_BW-1:0] row);
    logic [COLS*ADD_BW-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      r[c*ADD_BW +: MUL_BW] = row[c*MUL_BW +: MUL_BW];
    end
    return r;
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      top_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_ready_q <= w_ready_d;
      a_ready_q <= a_ready_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      top_q     <= top_d;
    end
  end

  // Weight tile buffer, row index = beat number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf_q <= '{default: '0};
    end else if (w_fire) begin
      wbuf_q[widx] <= s_if.w_data;
    end
  end

  // Next state and next registered outputs.
  // The last weight beat is forwarded straight to o_top because its buffer
  // row is written on the same edge, so SHIFT starts without a bubble.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_ready_d = 1'b0;
    a_ready_d = 1'b0;
    mode_d    = 1'b0;
    done_d    = 1'b0;
    top_d     = '0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = COLLECT;
          cnt_d     = '0;
          w_ready_d = 1'b1;
        end
      end
      COLLECT: begin
        w_ready_d = 1'b1;
        if (w_fire) begin
          cnt_d = cnt_q + ONE_C;
          if (cnt_q == ROWS_C - ONE_C) begin
            state_d   = SHIFT;
            w_ready_d = 1'b0;
            cnt_d     = ONE_C;
            top_d     = zext_row(s_if.w_data);
          end
        end
      end
      SHIFT: begin
        if (cnt_q == ROWS_C) begin
          state_d   = COMPUTE;
          mode_d    = 1'b1;
          a_ready_d = 1'b1;
        end else begin
          top_d = zext_row(wbuf_q[ridx]);
          cnt_d = cnt_q + ONE_C;
        end
      end
      COMPUTE: begin
        mode_d    = 1'b1;
        a_ready_d = 1'b1;
        if (a_fire && s_if.a_last) begin
          state_d   = DRAIN;
          a_ready_d = 1'b0;
          cnt_d     = ONE_C;
          done_d    = (DRAIN_C == ONE_C);
        end
      end
      DRAIN: begin
        mode_d = 1'b1;
        if (cnt_q == DRAIN_C) begin
          state_d = IDLE;
          mode_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q + ONE_C;
          done_d = (cnt_q + ONE_C == DRAIN_C);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [MUL_BW-1:0] inj;
    assign inj = a_fire ? s_if.a_data[r*MUL_BW +: MUL_BW] : '0;
    sa_skew_line #(
      .DEPTH(r),
      .W    (MUL_BW)
    ) u_line (
      .clk(clk),
      .rst(rst),
      .d_i(inj),
      .v_i(a_fire),
      .d_o(o_left[r*MUL_BW +: MUL_BW]),
      .v_o(o_row_valid[r])
    );
  end

`ifdef SA_EDGE_FEEDER_PERF_CNT_EN
  logic [31:0] bubble_q, wstall_q;

  // Saturating counters of idle stream cycles, cleared per job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
      wstall_q <= '0;
    end else if (state_q == IDLE && i_start) begin
      bubble_q <= '0;
      wstall_q <= '0;
    end else begin
      if (state_q == COMPUTE && !s_if.a_valid && bubble_q != '1) bubble_q <= bubble_q + 32'd1;
      if (state_q == COLLECT && !s_if.w_valid && wstall_q != '1) wstall_q <= wstall_q + 32'd1;
    end
  end

  assign o_bubble_cnt = bubble_q;
  assign o_wstall_cnt = wstall_q;
`endif

  assign s_if.w_ready = w_ready_q;
  assign s_if.a_ready = a_ready_q;
  assign o_mode       = mode_q;
  assign o_top        = top_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_sa_edge_feeder.sv
// Bench for sa_edge_feeder with a 2x2 array.
module tb_sa_edge_feeder;

  localparam int ROWS  = 2;
  localparam int COLS  = 2;
  localparam int MB    = 16;
  localparam int AB    = 32;
  localparam int DRAIN = ROWS + COLS - 1;

  logic clk = 1'b0;
  logic rst;
  logic i_start;
  logic o_mode;
  logic [COLS*AB-1:0] o_top;
  logic [ROWS*MB-1:0] o_left;
  logic [ROWS-1:0]    o_row_valid;
  logic o_busy, o_done;
`ifdef SA_EDGE_FEEDER_PERF_CNT_EN
  logic [31:0] o_bubble_cnt, o_wstall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [MB-1:0] d;
    int            due;
  } ent_t;

  ent_t lq [ROWS][$];
  logic [COLS*AB-1:0] tq [$];

  sa_edge_feeder_if #(.ROWS(ROWS), .COLS(COLS), .MUL_BW(MB)) sif ();

  sa_edge_feeder #(
    .ROWS(ROWS), .COLS(COLS), .MUL_BW(MB), .ADD_BW(AB), .PIPE_LAT(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .s_if(sif),
    .o_mode(o_mode),
    .o_top(o_top),
    .o_left(o_left),
    .o_row_valid(o_row_valid),
    .o_busy(o_busy),
    .o_done(o_done)
`ifdef SA_EDGE_FEEDER_PERF_CNT_EN
    ,
    .o_bubble_cnt(o_bubble_cnt),
    .o_wstall_cnt(o_wstall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; i_start = 1'b0;
    sif.w_valid = 1'b0; sif.w_data = '0;
    sif.a_valid = 1'b0; sif.a_last = 1'b0; sif.a_data = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if ({o_mode, o_busy, o_done, sif.w_ready, sif.a_ready, o_row_valid} !== '0) begin
      bad++; $display("FAIL reset_flags got=%b want=0", {o_mode, o_busy, o_done, sif.w_ready, sif.a_ready, o_row_valid});
    end
    total++;
    if (o_top !== '0) begin bad++; $display("FAIL reset_top got=%h want=0", o_top); end
    total++;
    if (o_left !== '0) begin bad++; $display("FAIL reset_left got=%h want=0", o_left); end
  endtask

  task automatic test_weight_shift(input bit stall);
    logic [COLS*MB-1:0] beats [ROWS];
    logic [COLS*AB-1:0] tops  [ROWS];
    logic [COLS*AB-1:0] exp_top;
    bit acc;
    beats[0] = 32'h3F80_4000; tops[0] = 64'h0000_3F80_0000_4000;
    beats[1] = 32'h4040_4080; tops[1] = 64'h0000_4040_0000_4080;
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL idle_before_start busy got=%b want=0", o_busy); end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    total++;
    if ({sif.w_ready, o_busy} !== 2'b11) begin
      bad++; $display("FAIL collect_entry ready_busy got=%b want=11", {sif.w_ready, o_busy});
    end
    for (int i = 0; i < ROWS; i++) begin
      if (stall && i == 1) begin sif.w_valid = 1'b0; tick(); end
      sif.w_valid = 1'b1;
      sif.w_data  = beats[i];
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++) begin
        if (sif.w_ready === 1'b1) begin tq.push_front(tops[i]); acc = 1'b1; end
        tick();
      end
      total++;
      if (!acc) begin bad++; $display("FAIL w_accept beat=%0d got=not_accepted want=accepted", i); end
    end
    sif.w_valid = 1'b0;
    for (int k = 0; k < ROWS; k++) begin
      exp_top = (tq.size() > 0) ? tq.pop_front() : '1;
      total++;
      if (o_top !== exp_top) begin bad++; $display("FAIL shift_top k=%0d got=%h want=%h", k, o_top, exp_top); end
      total++;
      if ({o_mode, sif.w_ready} !== 2'b00) begin
        bad++; $display("FAIL shift_mode k=%0d mode_wready got=%b want=00", k, {o_mode, sif.w_ready});
      end
      tick();
    end
    total++;
    if ({o_mode, sif.a_ready} !== 2'b11 || o_top !== '0) begin
      bad++; $display("FAIL compute_entry mode_aready got=%b top=%h want=11 top=0", {o_mode, sif.a_ready}, o_top);
    end
`ifdef SA_EDGE_FEEDER_PERF_CNT_EN
    total++;
    if (o_wstall_cnt !== (stall ? 32'd1 : 32'd0)) begin
      bad++; $display("FAIL wstall_cnt got=%0d want=%0d", o_wstall_cnt, stall ? 1 : 0);
    end
`endif
  endtask

  task automatic test_activations(input int n, input bit v [4], input logic [31:0] d [4], input bit noise);
    int idx = 0;
    bit last_sent = 1'b0;
    int p_last = 0;
    int done_due = -100;
    int done_cnt = 0;
    int bub_exp = 0;
    logic [MB-1:0] ed;
    logic ev;
    logic [1:0] exp_ma;
    logic exp_busy;
    ent_t e;
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < ROWS; r++) begin
        ed = '0; ev = 1'b0;
        if (lq[r].size() > 0 && lq[r][0].due == cyc) begin
          e = lq[r].pop_front(); ev = 1'b1; ed = e.d;
        end
        total++;
        if ({o_row_valid[r], o_left[r*MB +: MB]} !== {ev, ed}) begin
          bad++; $display("FAIL left row=%0d cyc=%0d got=v%b/%h want=v%b/%h", r, cyc, o_row_valid[r], o_left[r*MB +: MB], ev, ed);
        end
      end
      total++;
      if (o_done !== (cyc == done_due)) begin
        bad++; $display("FAIL done cyc=%0d got=%b want=%b", cyc, o_done, cyc == done_due);
      end
      if (o_done === 1'b1) done_cnt++;
      exp_ma   = !last_sent ? 2'b11 : ((cyc <= done_due) ? 2'b10 : 2'b00);
      exp_busy = !last_sent || (cyc <= done_due);
      total++;
      if ({sif.w_ready, o_mode, sif.a_ready, o_busy} !== {1'b0, exp_ma, exp_busy}) begin
        bad++; $display("FAIL flags cyc=%0d wready_mode_aready_busy got=%b want=%b", cyc,
                        {sif.w_ready, o_mode, sif.a_ready, o_busy}, {1'b0, exp_ma, exp_busy});
      end
      if (last_sent && cyc >= done_due + 2) break;
      i_start = 1'b0;
      sif.w_valid = 1'b0;
      if (noise && last_sent && cyc == p_last) begin
        i_start = 1'b1; sif.w_valid = 1'b1; sif.w_data = 32'hDEAD_BEEF;
      end
      if (idx < n) begin
        sif.a_valid = v[idx];
        sif.a_data  = d[idx];
        sif.a_last  = (idx == n - 1);
        if (!v[idx]) begin
          bub_exp++; idx++;
        end else if (sif.a_ready === 1'b1) begin
          for (int r = 0; r < ROWS; r++) begin
            e.d = d[idx][r*MB +: MB]; e.due = cyc + 1 + r;
            lq[r].push_back(e);
          end
          if (idx == n - 1) begin last_sent = 1'b1; p_last = cyc + 1; done_due = cyc + DRAIN; end
          idx++;
        end else begin
          total++; bad++; $display("FAIL a_accept cyc=%0d got=a_ready_0 want=1", cyc);
        end
      end else begin
        sif.a_valid = 1'b0; sif.a_last = 1'b0;
      end
      tick();
    end
    i_start = 1'b0; sif.w_valid = 1'b0; sif.a_valid = 1'b0; sif.a_last = 1'b0;
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL done_count got=%0d want=1", done_cnt); end
    total++;
    if (lq[0].size() + lq[1].size() != 0) begin
      bad++; $display("FAIL left_pending got=%0d want=0", lq[0].size() + lq[1].size());
      lq[0].delete(); lq[1].delete();
    end
`ifdef SA_EDGE_FEEDER_PERF_CNT_EN
    total++;
    if (o_bubble_cnt !== 32'(bub_exp)) begin bad++; $display("FAIL bubble_cnt got=%0d want=%0d", o_bubble_cnt, bub_exp); end
`endif
  endtask

  task automatic test_reset_mid_compute;
    test_weight_shift(1'b0);
    sif.a_valid = 1'b1; sif.a_data = 32'h5555_6666; sif.a_last = 1'b0;
    tick();
    sif.a_valid = 1'b0;
    total++;
    if ({o_row_valid[0], o_left[MB-1:0]} !== {1'b1, 16'h6666}) begin
      bad++; $display("FAIL pre_reset_row0 got=v%b/%h want=v1/6666", o_row_valid[0], o_left[MB-1:0]);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({o_mode, o_busy, o_done, sif.w_ready, sif.a_ready, o_row_valid} !== '0) begin
      bad++; $display("FAIL async_reset_flags got=%b want=0", {o_mode, o_busy, o_done, sif.w_ready, sif.a_ready, o_row_valid});
    end
    total++;
    if (o_top !== '0 || o_left !== '0) begin
      bad++; $display("FAIL async_reset_data top=%h left=%h want=0", o_top, o_left);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({o_done, o_busy, o_row_valid} !== '0 || o_left !== '0) begin
        bad++; $display("FAIL post_reset k=%0d done_busy_rv=%b left=%h want=0", k, {o_done, o_busy, o_row_valid}, o_left);
      end
    end
`ifdef SA_EDGE_FEEDER_PERF_CNT_EN
    total++;
    if ({o_bubble_cnt, o_wstall_cnt} !== '0) begin
      bad++; $display("FAIL post_reset_cnt got=%0d/%0d want=0/0", o_bubble_cnt, o_wstall_cnt);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit pv [4];
    logic [31:0] pd [4];
    test_reset();

    // single vector {0x4000,0x3F80} with last
    pv = '{1'b1, 1'b0, 1'b0, 1'b0};
    pd[0] = 32'h4000_3F80; pd[1] = '0; pd[2] = '0; pd[3] = '0;
    test_weight_shift(1'b0);
    test_activations(1, pv, pd, 1'b0);

    // stalled weights, bubbled activations, start/w_valid noise during drain
    pv = '{1'b1, 1'b0, 1'b1, 1'b0};
    pd[0] = 32'h1111_2222; pd[1] = 32'hAAAA_BBBB; pd[2] = 32'h3333_4444; pd[3] = '0;
    test_weight_shift(1'b1);
    test_activations(3, pv, pd, 1'b1);

    test_reset_mid_compute();

    pv = '{1'b1, 1'b1, 1'b0, 1'b0};
    pd[0] = 32'h7777_8888; pd[1] = 32'h9999_0001; pd[2] = '0; pd[3] = '0;
    test_weight_shift(1'b0);
    test_activations(2, pv, pd, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
